// File: rtl/sme_param_if.sv
// Character-stream bus between the host front end and the string matcher:
// host drives characters and qualifiers, the matcher returns the result strobe.
interface sme_param_if #(
  parameter int IDX_W = 5
) ();
  logic [7:0]       chardata;
  logic             isstring;
  logic             ispattern;
  logic             valid;
  logic             match;
  logic [IDX_W-1:0] match_index;

  modport master (
    output chardata, isstring, ispattern,
    input  valid, match, match_index
  );

  modport slave (
    input  chardata, isstring, ispattern,
    output valid, match, match_index
  );
endinterface

// File: rtl/sme_param.sv
// Parametrised string matcher: stores one string, then scans each pattern for
// the leftmost match, with '^', '$', '.' and a single '*' wildcard.
module sme_param #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int IDX_W   = $clog2(STR_MAX)
) (
  input logic        clk,
  input logic        reset,
  sme_param_if.slave bus
);
  localparam int LW  = IDX_W + 1;
  localparam int PLW = $clog2(PAT_MAX + 1);
  localparam int PIW = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;

  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_SPACE  = 8'h20;

  typedef enum logic [2:0] {IDLE, LOAD_STR, LOAD_PAT, SCAN_PRE, SCAN_SUF, DONE} state_e;

  state_e           state_q, state_d;
  logic [7:0]       str_q [STR_MAX];
  logic [7:0]       pat_q [PAT_MAX];
  logic [LW-1:0]    strLen_q, strLen_d;
  logic [PLW-1:0]   patLen_q, patLen_d;
  logic [LW-1:0]    pos_q, pos_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             match_q, match_d;
  logic [IDX_W-1:0] matchIdx_q, matchIdx_d;

  logic             strWe, patWe;
  logic [IDX_W-1:0] strAddr;
  logic [PIW-1:0]   patAddr;

  logic anchorS, anchorE, hasStar;
  int   bs, be, pl, sl, starPos, pLen, sLen, sStart, scanPos;
  logic preRoom, preFit, sufRoom, sufFit;

  // Split the stored pattern into prefix (before '*') and suffix (after it).
  always_comb begin
    pl      = int'(patLen_q);
    sl      = int'(strLen_q);
    anchorS = (pl > 0) && (pat_q[0] == CH_CARET);
    bs      = anchorS ? 1 : 0;
    anchorE = 1'b0;
    for (int k = 0; k < PAT_MAX; k++) begin
      if (k == pl - 1 && k >= bs && pat_q[k] == CH_DOLLAR) anchorE = 1'b1;
    end
    be      = anchorE ? pl - 1 : pl;
    hasStar = 1'b0;
    starPos = 0;
    for (int k = 0; k < PAT_MAX; k++) begin
      if (!hasStar && k >= bs && k < be && pat_q[k] == CH_STAR) begin
        hasStar = 1'b1;
        starPos = k;
      end
    end
    pLen   = hasStar ? starPos - bs : be - bs;
    sStart = starPos + 1;
    sLen   = hasStar ? be - sStart : 0;
  end

  always_comb begin
    scanPos = int'(pos_q);
    preRoom = (scanPos + pLen) <= sl;
    preFit  = preRoom;
    sufRoom = (scanPos + sLen) <= sl;
    sufFit  = sufRoom;
    for (int k = 0; k < PAT_MAX; k++) begin
      if (k < pLen && (scanPos + k) < STR_MAX && (bs + k) < PAT_MAX) begin
        if (pat_q[PIW'(bs + k)] != CH_DOT &&
            pat_q[PIW'(bs + k)] != str_q[IDX_W'(scanPos + k)]) preFit = 1'b0;
      end
      if (k < sLen && (scanPos + k) < STR_MAX && (sStart + k) < PAT_MAX) begin
        if (pat_q[PIW'(sStart + k)] != CH_DOT &&
            pat_q[PIW'(sStart + k)] != str_q[IDX_W'(scanPos + k)]) sufFit = 1'b0;
      end
    end
    if (anchorS && scanPos > 0 && scanPos <= STR_MAX &&
        str_q[IDX_W'(scanPos - 1)] != CH_SPACE) preFit = 1'b0;
    // With a '*' the end anchor belongs to the suffix, otherwise to the prefix.
    if (!hasStar && anchorE && (scanPos + pLen) < sl &&
        str_q[IDX_W'(scanPos + pLen)] != CH_SPACE) preFit = 1'b0;
    if (anchorE && (scanPos + sLen) < sl &&
        str_q[IDX_W'(scanPos + sLen)] != CH_SPACE) sufFit = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    strLen_d   = strLen_q;
    patLen_d   = patLen_q;
    pos_d      = pos_q;
    idx_d      = idx_q;
    match_d    = match_q;
    matchIdx_d = matchIdx_q;
    strWe      = 1'b0;
    strAddr    = '0;
    patWe      = 1'b0;
    patAddr    = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.isstring) begin
          strWe    = 1'b1;
          strLen_d = LW'(1);
          state_d  = LOAD_STR;
        end else if (bus.ispattern) begin
          patWe    = 1'b1;
          patLen_d = PLW'(1);
          state_d  = LOAD_PAT;
        end
      end
      LOAD_STR: begin
        if (!bus.isstring) begin
          state_d = IDLE;
        end else if (strLen_q < LW'(STR_MAX)) begin
          strWe    = 1'b1;
          strAddr  = strLen_q[IDX_W-1:0];
          strLen_d = strLen_q + LW'(1);
        end
      end
      LOAD_PAT: begin
        if (bus.ispattern) begin
          if (patLen_q < PLW'(PAT_MAX)) begin
            patWe    = 1'b1;
            patAddr  = patLen_q[PIW-1:0];
            patLen_d = patLen_q + PLW'(1);
          end
        end else begin
          pos_d = '0;
          idx_d = '0;
          if (pLen != 0) begin
            state_d = SCAN_PRE;
          end else if (hasStar) begin
            state_d = SCAN_SUF;
          end else begin
            match_d    = 1'b1;
            matchIdx_d = '0;
            state_d    = DONE;
          end
        end
      end
      SCAN_PRE: begin
        if (!preRoom) begin
          match_d    = 1'b0;
          matchIdx_d = '0;
          state_d    = DONE;
        end else if (preFit && hasStar) begin
          idx_d   = pos_q[IDX_W-1:0];
          pos_d   = LW'(scanPos + pLen);
          state_d = SCAN_SUF;
        end else if (preFit) begin
          match_d    = 1'b1;
          matchIdx_d = pos_q[IDX_W-1:0];
          state_d    = DONE;
        end else begin
          pos_d = pos_q + LW'(1);
        end
      end
      SCAN_SUF: begin
        if (!sufRoom) begin
          match_d    = 1'b0;
          matchIdx_d = '0;
          state_d    = DONE;
        end else if (sufFit) begin
          match_d    = 1'b1;
          matchIdx_d = idx_q;
          state_d    = DONE;
        end else begin
          pos_d = pos_q + LW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      strLen_q   <= '0;
      patLen_q   <= '0;
      pos_q      <= '0;
      idx_q      <= '0;
      match_q    <= 1'b0;
      matchIdx_q <= '0;
    end else begin
      state_q    <= state_d;
      strLen_q   <= strLen_d;
      patLen_q   <= patLen_d;
      pos_q      <= pos_d;
      idx_q      <= idx_d;
      match_q    <= match_d;
      matchIdx_q <= matchIdx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (strWe) str_q[strAddr] <= bus.chardata;
    if (patWe) pat_q[patAddr] <= bus.chardata;
  end

  assign bus.valid       = (state_q == DONE);
  assign bus.match       = match_q;
  assign bus.match_index = matchIdx_q;

endmodule
